// File: rtl/risc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC controller: states, mux selects,
// IR type/opcode constants and the decoded instruction class.
package risc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [1:0] PC_PLUS1  = 2'd0;
  localparam logic [1:0] PC_JUMP   = 2'd1;
  localparam logic [1:0] PC_BRANCH = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  localparam logic [1:0] TYPE_R = 2'b00;
  localparam logic [1:0] TYPE_J = 2'b01;
  localparam logic [1:0] TYPE_I = 2'b10;
  localparam logic [1:0] TYPE_S = 2'b11;

  localparam logic [4:0] OP_AND  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_CMP  = 5'd3;
  localparam logic [4:0] OP_J    = 5'd0;
  localparam logic [4:0] OP_JAL  = 5'd1;
  localparam logic [4:0] OP_ANDI = 5'd0;
  localparam logic [4:0] OP_ADDI = 5'd1;
  localparam logic [4:0] OP_LW   = 5'd2;
  localparam logic [4:0] OP_SW   = 5'd3;
  localparam logic [4:0] OP_BEQ  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd0;
  localparam logic [4:0] OP_SLR  = 5'd1;
  localparam logic [4:0] OP_SLLV = 5'd2;
  localparam logic [4:0] OP_SLRV = 5'd3;

  typedef enum logic [3:0] {
    C_ALU_REG   = 4'd0,
    C_ALU_IMM   = 4'd1,
    C_SHIFT_IMM = 4'd2,
    C_SHIFT_REG = 4'd3,
    C_LOAD      = 4'd4,
    C_STORE     = 4'd5,
    C_BRANCH    = 4'd6,
    C_JUMP      = 4'd7,
    C_JAL       = 4'd8,
    C_ILLEGAL   = 4'd9
  } iclass_t;

  // Classes whose ALU B operand comes from the immediate/shamt latch.
  function automatic logic uses_imm(iclass_t c);
    return (c == C_ALU_IMM) || (c == C_SHIFT_IMM) || (c == C_LOAD) || (c == C_STORE);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational IR type/opcode to instruction-class decode.
module ctrl_decode
  import risc_ctrl_pkg::*;
(
  input  logic [1:0] instr_type,
  input  logic [4:0] instr_op,
  output iclass_t    iclass
);

  always_comb begin
    iclass = C_ILLEGAL;
    case (instr_type)
      TYPE_R: if (instr_op <= OP_CMP) iclass = C_ALU_REG;
      TYPE_J: begin
        if (instr_op == OP_J)        iclass = C_JUMP;
        else if (instr_op == OP_JAL) iclass = C_JAL;
      end
      TYPE_I: begin
        case (instr_op)
          OP_ANDI, OP_ADDI: iclass = C_ALU_IMM;
          OP_LW:            iclass = C_LOAD;
          OP_SW:            iclass = C_STORE;
          OP_BEQ:           iclass = C_BRANCH;
          default:          iclass = C_ILLEGAL;
        endcase
      end
      TYPE_S: begin
        case (instr_op)
          OP_SLL, OP_SLR:   iclass = C_SHIFT_IMM;
          OP_SLLV, OP_SLRV: iclass = C_SHIFT_REG;
          default:          iclass = C_ILLEGAL;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory ready handshakes and datapath enable/select generation.
module multicycle_ctrl
  import risc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [1:0] instr_type,
  input  logic [4:0] instr_op,
  input  logic       alu_zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_we,
  output logic       ab_we,
  output logic       alu_src_b,
  output logic       alu_out_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       mdr_we,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       illegal,
  output logic [2:0] state
);

  state_t  state_q, state_d, boundary;
  iclass_t iclass;

  ctrl_decode u_decode (
    .instr_type (instr_type),
    .instr_op   (instr_op),
    .iclass     (iclass)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign state    = state_q;
  assign boundary = run ? S_FETCH : S_IDLE;

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    ab_we      = 1'b0;
    alu_src_b  = 1'b0;
    alu_out_we = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_PLUS1;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    mdr_we     = 1'b0;
    reg_we     = 1'b0;
    wb_sel     = WB_ALU;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          pc_src  = PC_PLUS1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ab_we = 1'b1;
        case (iclass)
          C_ILLEGAL: begin
            illegal = 1'b1;
            retire  = 1'b1;
            state_d = boundary;
          end
          C_JUMP, C_JAL: begin
            pc_we   = 1'b1;
            pc_src  = PC_JUMP;
            retire  = 1'b1;
            state_d = boundary;
            // PC already holds PC+1 from FETCH, so the link value is ready.
            if (iclass == C_JAL) begin
              reg_we = 1'b1;
              wb_sel = WB_PC;
            end
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        alu_out_we = 1'b1;
        alu_src_b  = uses_imm(iclass);
        case (iclass)
          C_BRANCH: begin
            pc_we   = alu_zero;
            pc_src  = PC_BRANCH;
            retire  = 1'b1;
            state_d = boundary;
          end
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (iclass == C_STORE);
        if (dmem_ready) begin
          if (iclass == C_STORE) begin
            retire  = 1'b1;
            state_d = boundary;
          end else begin
            mdr_we  = 1'b1;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        wb_sel  = (iclass == C_LOAD) ? WB_MDR : WB_ALU;
        retire  = 1'b1;
        state_d = boundary;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: per-instruction event counts and latency compared
// against a class/latency model derived from the instruction table.
module tb_multicycle_ctrl;
  import risc_ctrl_pkg::*;

  logic       clk, rst_n, run, alu_zero, imem_ready, dmem_ready;
  logic [1:0] instr_type;
  logic [4:0] instr_op;
  logic       imem_req, ir_we, ab_we, alu_src_b, alu_out_we, pc_we;
  logic [1:0] pc_src, wb_sel;
  logic       dmem_req, dmem_we, mdr_we, reg_we, retire, illegal;
  logic [2:0] state;

  int checks = 0;
  int fails  = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr_type(instr_type), .instr_op(instr_op),
    .alu_zero(alu_zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_we(ir_we), .ab_we(ab_we), .alu_src_b(alu_src_b),
    .alu_out_we(alu_out_we), .pc_we(pc_we), .pc_src(pc_src), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .mdr_we(mdr_we), .reg_we(reg_we), .wb_sel(wb_sel),
    .retire(retire), .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [15:0] all_out = {imem_req, ir_we, ab_we, alu_src_b, alu_out_we, pc_we, pc_src,
                         dmem_req, dmem_we, mdr_we, reg_we, wb_sel, retire, illegal};

  // Model kinds: 0 reg-operand ALU/shift, 1 imm ALU/shift, 2 LW, 3 SW, 4 BEQ, 5 J, 6 JAL, 7 illegal
  function automatic int kind_of(logic [1:0] ty, logic [4:0] op);
    case (ty)
      2'b00:   return (op <= 3) ? 0 : 7;
      2'b01:   return (op == 0) ? 5 : (op == 1) ? 6 : 7;
      2'b10:   return (op <= 1) ? 1 : (op == 2) ? 2 : (op == 3) ? 3 : (op == 4) ? 4 : 7;
      default: return (op <= 1) ? 1 : (op <= 3) ? 0 : 7;
    endcase
  endfunction

  task automatic run_instr(input logic [1:0] ty, input logic [4:0] op, input int iw,
                           input int dw, input logic z, input logic run_after, input string nm);
    int k, lat, exp_lat, iwl, dwl, reg_cyc;
    int n_ireq, n_ir, n_ab, n_reg, n_pcw, n_alu, n_dreq, n_dwe, n_mdr, n_ill, n_ret;
    int e_reg, e_alu, e_dreq, e_dwe;
    logic [1:0] got_wb, e_wb;
    logic got_srcb, e_srcb, started, done, mem;
    logic [7:0] hist, e_hist;
    k = kind_of(ty, op);
    instr_type = ty; instr_op = op; alu_zero = z; run = 1'b1;
    iwl = iw; dwl = dw; lat = 0; reg_cyc = 0; started = 0; done = 0;
    n_ireq = 0; n_ir = 0; n_ab = 0; n_reg = 0; n_pcw = 0; n_alu = 0;
    n_dreq = 0; n_dwe = 0; n_mdr = 0; n_ill = 0; n_ret = 0;
    got_wb = 0; got_srcb = 0; hist = 0;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      @(negedge clk);
      imem_ready = imem_req ? (iwl == 0) : 1'($urandom_range(0, 1));
      if (imem_req && iwl > 0) iwl--;
      dmem_ready = dmem_req ? (dwl == 0) : 1'($urandom_range(0, 1));
      if (dmem_req && dwl > 0) dwl--;
      #1;
      if (!started) begin
        if (!imem_req) continue;
        started = 1; run = run_after;
      end
      lat++;
      if (imem_req) n_ireq++;
      if (ir_we) n_ir++;
      if (ab_we) n_ab++;
      if (reg_we) begin n_reg++; reg_cyc = lat; got_wb = wb_sel; end
      if (pc_we) begin n_pcw++; hist = {hist[5:0], pc_src}; end
      if (alu_out_we) begin n_alu++; got_srcb = alu_src_b; end
      if (dmem_req) begin n_dreq++; if (dmem_we) n_dwe++; end
      if (mdr_we) n_mdr++;
      if (illegal) n_ill++;
      if (retire) begin n_ret++; done = 1; end
    end
    checks++;
    if (!done) begin
      fails++; $display("FAIL %s timeout: no retire within 80 cycles", nm);
      return;
    end
    mem = (k == 2) || (k == 3);
    exp_lat = ((k >= 5) ? 2 : (k == 4) ? 3 : (k == 2) ? 5 : 4) + iw + (mem ? dw : 0);
    e_reg  = (k <= 2 || k == 6) ? 1 : 0;
    e_wb   = (k == 2) ? 2'd1 : (k == 6) ? 2'd2 : 2'd0;
    e_hist = (k == 5 || k == 6) ? 8'b0000_0001 : (k == 4 && z) ? 8'b0000_0010 : 8'b0;
    e_alu  = (k <= 4) ? 1 : 0;
    e_srcb = (k >= 1 && k <= 3);
    e_dreq = mem ? dw + 1 : 0;
    e_dwe  = (k == 3) ? dw + 1 : 0;
    checks += 12;
    if (lat !== exp_lat) begin fails++; $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat); end
    if (n_ret !== 1) begin fails++; $display("FAIL %s retire_count: got %0d want 1", nm, n_ret); end
    if (n_ireq !== iw + 1) begin fails++; $display("FAIL %s imem_req_cycles: got %0d want %0d", nm, n_ireq, iw + 1); end
    if (n_ir !== 1) begin fails++; $display("FAIL %s ir_we_count: got %0d want 1", nm, n_ir); end
    if (n_ab !== 1) begin fails++; $display("FAIL %s ab_we_count: got %0d want 1", nm, n_ab); end
    if (n_reg !== e_reg) begin fails++; $display("FAIL %s reg_we_count: got %0d want %0d", nm, n_reg, e_reg); end
    if (hist !== e_hist) begin fails++; $display("FAIL %s pc_write_history: got %b want %b", nm, hist, e_hist); end
    if (n_alu !== e_alu) begin fails++; $display("FAIL %s alu_out_we_count: got %0d want %0d", nm, n_alu, e_alu); end
    if (n_dreq !== e_dreq) begin fails++; $display("FAIL %s dmem_req_cycles: got %0d want %0d", nm, n_dreq, e_dreq); end
    if (n_dwe !== e_dwe) begin fails++; $display("FAIL %s dmem_we_cycles: got %0d want %0d", nm, n_dwe, e_dwe); end
    if (n_mdr !== ((k == 2) ? 1 : 0)) begin fails++; $display("FAIL %s mdr_we_count: got %0d want %0d", nm, n_mdr, (k == 2) ? 1 : 0); end
    if (n_ill !== ((k == 7) ? 1 : 0)) begin fails++; $display("FAIL %s illegal_count: got %0d want %0d", nm, n_ill, (k == 7) ? 1 : 0); end
    if (e_reg == 1) begin
      checks += 2;
      if (reg_cyc !== lat) begin fails++; $display("FAIL %s reg_we_cycle: got %0d want %0d", nm, reg_cyc, lat); end
      if (got_wb !== e_wb) begin fails++; $display("FAIL %s wb_sel: got %0d want %0d", nm, got_wb, e_wb); end
    end
    if (e_alu == 1) begin
      checks++;
      if (got_srcb !== e_srcb) begin fails++; $display("FAIL %s alu_src_b: got %0b want %0b", nm, got_srcb, e_srcb); end
    end
    @(posedge clk); #1;
    checks++;
    if (state !== (run_after ? 3'(S_FETCH) : 3'(S_IDLE)))
      begin fails++; $display("FAIL %s next_state: got %0d want %0d", nm, state, run_after ? 3'(S_FETCH) : 3'(S_IDLE)); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1; instr_type = 2'b00; instr_op = 5'd1;
    alu_zero = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
    #3;
    checks += 2;
    if (state !== 3'(S_IDLE)) begin fails++; $display("FAIL reset_state: got %0d want %0d", state, 3'(S_IDLE)); end
    if (all_out !== 16'h0) begin fails++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    @(posedge clk); #1;
    checks++;
    if (state !== 3'(S_IDLE)) begin fails++; $display("FAIL reset_hold: got %0d want %0d", state, 3'(S_IDLE)); end
    @(negedge clk); rst_n = 1'b1; run = 1'b0;
  endtask

  task automatic test_reset_mid_sw();
    logic found;
    found = 0;
    instr_type = 2'b10; instr_op = 5'd3; run = 1'b1; dmem_ready = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk); imem_ready = 1'b1; #1;
      if (dmem_req) found = 1;
    end
    checks++;
    if (!found) begin fails++; $display("FAIL sw_reach_mem: dmem_req never seen"); end
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 2;
    if (state !== 3'(S_IDLE)) begin fails++; $display("FAIL sw_reset_state: got %0d want %0d", state, 3'(S_IDLE)); end
    if (all_out !== 16'h0) begin fails++; $display("FAIL sw_reset_outputs: got %h want 0", all_out); end
    @(negedge clk); rst_n = 1'b1; run = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (state !== 3'(S_IDLE) || imem_req !== 1'b0)
      begin fails++; $display("FAIL sw_after_reset: state %0d imem_req %0b want 0 0", state, imem_req); end
  endtask

  task automatic test_idle_hold();
    run_instr(2'b00, 5'd2, 0, 0, 1'b0, 1'b0, "sub_stop");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); imem_ready = 1'b1; #1;
      checks++;
      if (state !== 3'(S_IDLE) || imem_req !== 1'b0)
        begin fails++; $display("FAIL idle_hold: state %0d imem_req %0b want 0 0", state, imem_req); end
    end
  endtask

  task automatic test_random();
    logic [1:0] ty;
    logic [4:0] op;
    for (int n = 0; n < 60; n++) begin
      ty = 2'($urandom_range(0, 3));
      op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      run_instr(ty, op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) != 0), "random");
    end
  endtask

  initial begin
    test_reset();
    run_instr(2'b00, 5'd1, 0, 0, 1'b0, 1'b1, "add");
    run_instr(2'b10, 5'd2, 0, 2, 1'b0, 1'b1, "lw_wait2");
    run_instr(2'b10, 5'd4, 0, 0, 1'b1, 1'b1, "beq_taken");
    run_instr(2'b10, 5'd4, 0, 0, 1'b0, 1'b1, "beq_not_taken");
    run_instr(2'b01, 5'd1, 0, 0, 1'b0, 1'b1, "jal");
    run_instr(2'b01, 5'd5, 0, 0, 1'b0, 1'b1, "illegal_j5");
    run_instr(2'b11, 5'd0, 2, 0, 1'b0, 1'b1, "sll_iwait");
    run_instr(2'b10, 5'd3, 1, 1, 1'b0, 1'b0, "sw_stop");
    test_idle_hold();
    test_reset_mid_sw();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle main controller for the simple RISC core. Sequences each instruction through fetch, decode, execute, memory and write-back, and drives the write enables and mux selects for the PC, IR, operand latches, register file and data memory. Handles ready/req handshakes to instruction and data memory. ALU operation selection stays in the existing ALU control decoder, which is fed from the same IR fields.

## Interface
Parameters: none. All encodings are constants in `risc_ctrl_pkg`.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: start/continue execution. Sampled only at instruction boundaries.
- `instr_type` in 2: IR type field. 00 R, 01 J, 10 I, 11 S.
- `instr_op` in 5: IR opcode field.
- `alu_zero` in 1: ALU zero flag from the EXEC cycle.
- `imem_ready` in 1: instruction memory ready (data valid).
- `dmem_ready` in 1: data memory access complete.
- `imem_req` out 1: instruction fetch request.
- `ir_we` out 1: IR load.
- `ab_we` out 1: load the A/B operand latches and the immediate latch.
- `alu_src_b` out 1: ALU B operand select. 0 register, 1 immediate/shamt.
- `alu_out_we` out 1: ALU result latch.
- `pc_we` out 1: PC write.
- `pc_src` out 2: PC source. 0 PC+1, 1 jump target, 2 branch target.
- `dmem_req` out 1: data memory request.
- `dmem_we` out 1: data memory write. Valid only with `dmem_req`.
- `mdr_we` out 1: memory data register load.
- `reg_we` out 1: register file write.
- `wb_sel` out 2: write-back source. 0 ALU out, 1 MDR, 2 PC (link).
- `retire` out 1: one-cycle pulse in the final cycle of every instruction, including illegal ones.
- `illegal` out 1: one-cycle pulse when an unsupported type/opcode is decoded.
- `state` out 3: current state, for debug.

## Operation
Instruction classes are produced by a combinational decode of `instr_type` and `instr_op`:
- R-type: op 0–3 (AND, ADD, SUB, CMP) → ALU_REG.
- J-type: op 0 (J) → JUMP; op 1 (JAL) → JAL.
- I-type:
  - op 0–1 (ANDI, ADDI) → ALU_IMM.
  - op 2 (LW) → LOAD.
  - op 3 (SW) → STORE.
  - op 4 (BEQ) → BRANCH.
- S-type: op 0–1 (SLL, SLR) → SHIFT_IMM; op 2–3 (SLLV, SLRV) → SHIFT_REG.
- Any other opcode → ILLEGAL.

States and their actions:
- IDLE: all outputs 0. Go to FETCH when `run`=1.
- FETCH:
  - `imem_req`=1 and held until `imem_ready`.
  - In the cycle `imem_ready`=1: `ir_we`=1, `pc_we`=1, `pc_src`=0, then go to DECODE.
- DECODE: `ab_we`=1. Next state depends on class:
  - ILLEGAL: `illegal`=1, `retire`=1, go to the boundary.
  - JUMP: `pc_we`=1, `pc_src`=1, `retire`=1, go to the boundary.
  - JAL: as JUMP, plus `reg_we`=1, `wb_sel`=2 (links the already-incremented PC).
  - All other classes: go to EXEC.
- EXEC: `alu_out_we`=1. `alu_src_b`=1 for ALU_IMM, SHIFT_IMM, LOAD, STORE; 0 otherwise. Next state:
  - BRANCH: `pc_we`=`alu_zero`, `pc_src`=2, `retire`=1, go to the boundary.
  - LOAD, STORE: go to MEM.
  - All other classes: go to WB.
- MEM:
  - `dmem_req`=1 and held until `dmem_ready`; `dmem_we`=1 for STORE.
  - On `dmem_ready`, LOAD: `mdr_we`=1, then go to WB.
  - On `dmem_ready`, STORE: `retire`=1, go to the boundary.
- WB: `reg_we`=1, `wb_sel`=1 for LOAD, 0 otherwise. `retire`=1, go to the boundary. CMP writes back like SUB.
- Boundary: the next state is FETCH if `run`=1, else IDLE.

## Timing
- Reset: state=IDLE and every output 0, taking effect immediately and asynchronously. Reset mid-instruction abandons the instruction with no further writes.
- Output gating: outputs are combinational from state, class and ready. Enables qualified by ready (`ir_we`, `pc_we` in FETCH, `mdr_we`) are 0 whenever the matching ready is low.
- Ready in the same cycle as req is accepted (zero wait). Ready while req is low is ignored.
- IR fields are sampled only from DECODE onward; IR changes only in FETCH.
- `run` deasserted mid-instruction: the instruction completes, then the controller goes to IDLE.
- Latency with zero-wait memories, counting the FETCH cycle:
  - J, JAL, illegal: 2 cycles.
  - BEQ: 3 cycles.
  - R, S, ANDI, ADDI, SW: 4 cycles.
  - LW: 5 cycles.
- Each memory wait cycle adds one cycle.
- `retire` occurs exactly once per instruction, in its last cycle.

## Structure
- `risc_ctrl_pkg` holds:
  - state enum: IDLE, FETCH, DECODE, EXEC, MEM, WB.
  - `pc_src` and `wb_sel` encodings.
  - type codes and per-type opcode constants.
  - class enum.
- Sub-module `ctrl_decode`: combinational mapping of type/op to class.
- `multicycle_ctrl` contains the state register and the output logic.

## Test plan
- ADD (type 00, op 00001) with `imem_ready` tied to 1: states FETCH→DECODE→EXEC→WB.
  - `reg_we`=1 with `wb_sel`=0 only in cycle 4.
  - `retire` pulses in cycle 4; `alu_src_b`=0.
- LW with 2 data wait cycles:
  - `dmem_req` is held 3 cycles with `dmem_we`=0.
  - `mdr_we` asserts in the ready cycle.
  - WB follows with `wb_sel`=1; 7 cycles total.
- BEQ run twice:
  - With `alu_zero`=1: `pc_we`=1 and `pc_src`=2 in EXEC.
  - With `alu_zero`=0: no PC write.
  - Both take 3 cycles and retire.
- JAL, then type 01 op 00101:
  - JAL: `pc_src`=1, `reg_we`=1, `wb_sel`=2 in DECODE.
  - Illegal opcode: `illegal` and `retire` pulse in DECODE with no register or memory write, and the next FETCH follows.
- Reset corner cases:
  - `rst_n` asserted during a stalled MEM cycle of SW: state goes to IDLE and `dmem_req` drops to 0 immediately.
  - With `run`=0 at the end of an instruction: IDLE is held and `imem_req` stays 0.
